ser_par_shift_in: RTL and testbench
===================================

Name: ser_par_shift_in

Overview:
- Serial-in/parallel-out receive shift register, MSB first.
- Receive-side counterpart of the board's load/shift parallel-to-serial transmitter: captures bit-strobed serial data and assembles WIDTH-bit words.
- Presents each word on a held parallel register with a valid/ack handshake to the bus-side logic.
- Flags overrun when a word completes before the previous one is acknowledged.

Parameters:
- WIDTH, 8, bits per word; legal range 2..16.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  reset, synchronous, active-high.
- SerIn  input  1  serial data; sampled only when bit_stb=1.
- bit_stb  input  1  one-cycle strobe: sample SerIn this cycle.
- sync  input  1  word-boundary resync; discards any partial word.
- rx_ack  input  1  consumer accepts ParOut; honoured only while rx_valid=1.
- ovr_clr  input  1  clears the sticky overrun flag.
- ParOut  output  WIDTH  last completed word, bit WIDTH-1 = first bit received.
- rx_valid  output  1  ParOut holds an unacknowledged word.
- busy  output  1  partial word in progress (bit count != 0).
- overrun  output  1  sticky: a completed word overwrote an unacknowledged word.

Behaviour:
- Reset (clr=1 at an edge): shift reg=0, bit count=0, ParOut=0, rx_valid=0, overrun=0, busy=0. Reset overrides every other input, including mid-word; the partial word is lost.
- State: COLLECT (count 0..WIDTH-1) only; word completion is a single-cycle event, not a separate state.
- bit_stb=1, sync=0: shreg <= {shreg[WIDTH-2:0], SerIn}; count <= count+1.
- Completion: bit_stb=1 while count==WIDTH-1.
  - ParOut <= {shreg[WIDTH-2:0], SerIn}.
  - count <= 0; rx_valid <= 1.
  - Latency: ParOut and rx_valid are visible the cycle after the last strobe.
- bit_stb=0, sync=0: shreg and count hold.
- sync=1:
  - count <= 0 and partial data is discarded (shreg <= 0).
  - If bit_stb=1 in the same cycle, that bit is taken as the first bit of the new word: shreg <= {0.., SerIn}, count <= 1.
  - sync never affects ParOut, rx_valid or overrun.
- Handshake:
  - rx_ack=1 while rx_valid=1 and no completion this cycle: rx_valid <= 0; ParOut holds its value.
  - rx_ack while rx_valid=0: ignored.
- Completion while rx_valid=1 and rx_ack=0: ParOut is overwritten with the new word, rx_valid stays 1, overrun <= 1.
- Completion and rx_ack in the same cycle: the old word counts as consumed; new word latched, rx_valid stays 1, no overrun.
- overrun is cleared only by clr or ovr_clr. If ovr_clr and a new overrun occur in the same cycle, set wins (overrun=1).
- busy = (count != 0), combinational from the registered count.
- Strobes arriving back-to-back every cycle are supported at full rate, one bit per clock.

Decomposition:
- Shared package (shift_pkg): WIDTH default, CNT_W, and a localparam LAST_BIT = WIDTH-1, shared with the transmit shift register.
- Sub-module: one, ser_par_bitcnt, a CNT_W-bit counter with clear, increment, load-1 and terminal-count output.
- Shift register and handshake/overrun logic stay in the top module.

Test Plan:
- clr=1 for 2 cycles, then release -> ParOut=0x00, rx_valid=0, overrun=0, busy=0.
- Strobe bits 1,0,1,0,0,1,0,1 on consecutive cycles -> the cycle after the 8th strobe shows ParOut=0xA5 and rx_valid=1, with busy=1 after strobe 1.
- Hold rx_valid unacked, then strobe 0x3C -> ParOut=0x3C, overrun=1. Assert ovr_clr -> overrun=0 next cycle, ParOut still 0x3C.
- rx_ack in the same cycle as the 8th strobe of 0xFF -> rx_valid stays 1, ParOut=0xFF, overrun=0. rx_ack next cycle -> rx_valid=0.
- Strobe 3 bits, then sync with bit_stb=1 and SerIn=1, then 7 more bits 0000001 -> ParOut=0x81; the partial 3 bits are discarded.
- Assert clr after the 5th strobe of a word -> count=0 and busy=0 with no word emitted; the next full 8 strobes of 0x5A yield ParOut=0x5A.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared word-size constants for the serial shift registers (tx and rx)
package shift_pkg;
  localparam int SHIFT_WIDTH    = 8;
  localparam int SHIFT_CNT_W    = 4;
  localparam int SHIFT_LAST_BIT = SHIFT_WIDTH - 1;
endpackage

// File: rtl/ser_par_bitcnt.sv
// ser_par_bitcnt: bit counter with sync clear, increment, load-1 and terminal count
// Ports: clk, rst (sync reset), clr_i (clear to 0), ld1_i (load 1, overrides clr_i),
//        inc_i (count up, wraps to 0 at LAST), cnt_o (count), tc_o (count == LAST)
module ser_par_bitcnt
  import shift_pkg::*;
#(
  parameter int CNT_W = SHIFT_CNT_W,
  parameter int LAST  = SHIFT_LAST_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             ld1_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tc_o  = cnt_q == CNT_W'(LAST);
  assign cnt_o = cnt_q;
  always_comb cnt_d = ld1_i ? CNT_W'(1) : clr_i ? '0 : inc_i ? (tc_o ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/ser_par_shift_in.sv
// ser_par_shift_in: MSB-first serial-in/parallel-out receiver with valid/ack and sticky overrun
// Ports: clk, clr (sync reset), SerIn/bit_stb (strobed serial data), sync (drop partial word),
//        rx_ack (consume ParOut), ovr_clr (clear overrun), ParOut (last word), rx_valid,
//        busy (partial word in progress), overrun (word overwritten before ack)
module ser_par_shift_in
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int CNT_W = SHIFT_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             SerIn,
  input  logic             bit_stb,
  input  logic             sync,
  input  logic             rx_ack,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] ParOut,
  output logic             rx_valid,
  output logic             busy,
  output logic             overrun
);
  logic [WIDTH-1:0] shreg_q, shreg_d, par_q, par_d, shifted;
  logic             valid_q, valid_d, ovr_q, ovr_d, tc, done;
  logic [CNT_W-1:0] cnt;
  ser_par_bitcnt #(.CNT_W(CNT_W), .LAST(WIDTH - 1)) u_cnt (
    .clk  (clk),
    .rst  (clr),
    .clr_i(sync),
    .inc_i(bit_stb),
    .ld1_i(sync & bit_stb),
    .cnt_o(cnt),
    .tc_o (tc)
  );
  assign shifted = {shreg_q[WIDTH-2:0], SerIn};
  // a strobe alongside sync starts a new word, so it can never complete one
  assign done = bit_stb & ~sync & tc;
  always_comb begin
    shreg_d = sync ? {{(WIDTH-1){1'b0}}, SerIn & bit_stb} : bit_stb ? shifted : shreg_q;
    par_d   = done ? shifted : par_q;
    valid_d = done | (valid_q & ~rx_ack);
    // an ack in the completing cycle consumes the old word; a new overrun beats ovr_clr
    ovr_d   = (done & valid_q & ~rx_ack) | (ovr_q & ~ovr_clr);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      shreg_q <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign ParOut   = par_q;
  assign rx_valid = valid_q;
  assign overrun  = ovr_q;
  assign busy     = |cnt;
endmodule

// File: tb/tb_ser_par_shift_in.sv
// tb_ser_par_shift_in: directed plus random stimulus against a word-level reference model
module tb_ser_par_shift_in;
  localparam int W = 8;
  logic clk = 1'b0, clr = 1'b1, SerIn = 1'b0, bit_stb = 1'b0, sync = 1'b0, rx_ack = 1'b0, ovr_clr = 1'b0;
  logic [W-1:0] ParOut;
  logic rx_valid, busy, overrun;
  int checks = 0, errors = 0;
  int m_n = 0, m_val = 0, m_par = 0;
  bit m_valid = 1'b0, m_ovr = 1'b0;
  always #5 clk = ~clk;
  ser_par_shift_in #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .SerIn(SerIn), .bit_stb(bit_stb), .sync(sync),
    .rx_ack(rx_ack), .ovr_clr(ovr_clr), .ParOut(ParOut), .rx_valid(rx_valid),
    .busy(busy), .overrun(overrun)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, "_par"}, 16'(ParOut), 16'(m_par));
    chk({tag, "_valid"}, 16'(rx_valid), 16'(m_valid));
    chk({tag, "_busy"}, 16'(busy), 16'(m_n != 0));
    chk({tag, "_ovr"}, 16'(overrun), 16'(m_ovr));
  endtask
  // model: m_n bits of the current word received so far, m_val their value MSB-first
  task automatic step(input bit sin, input bit stb, input bit sy, input bit ack, input bit oc, input bit rst, input string tag);
    bit done;
    SerIn = sin; bit_stb = stb; sync = sy; rx_ack = ack; ovr_clr = oc; clr = rst;
    done = 1'b0;
    if (rst) begin
      m_n = 0; m_val = 0; m_par = 0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      if (sy) begin
        m_n = stb ? 1 : 0;
        m_val = (stb && sin) ? 1 : 0;
      end else if (stb) begin
        m_val = (m_val * 2 + int'(sin)) % (1 << W);
        m_n++;
        if (m_n == W) begin done = 1'b1; m_n = 0; end
      end
      if (oc) m_ovr = 1'b0;
      if (done) begin
        if (m_valid && !ack) m_ovr = 1'b1;
        m_par = m_val;
        m_valid = 1'b1;
      end else if (ack) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask
  task automatic send_word(input logic [W-1:0] w, input bit ack_last, input string tag);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, ack_last && i == 0, 1'b0, 1'b0, tag);
  endtask
  initial begin
    logic [W-1:0] a5 = 8'hA5;
    step(0, 0, 0, 0, 0, 1, "rst");
    step(0, 0, 0, 0, 0, 1, "rst");
    chk("rst_par", 16'(ParOut), 16'h00);
    chk("rst_valid", 16'(rx_valid), 16'h0);
    chk("rst_ovr", 16'(overrun), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    step(0, 0, 0, 0, 0, 0, "idle");
    step(a5[7], 1, 0, 0, 0, 0, "a5");
    chk("a5_busy1", 16'(busy), 16'h1);
    for (int i = 6; i >= 0; i--) step(a5[i], 1, 0, 0, 0, 0, "a5");
    chk("a5_par", 16'(ParOut), 16'hA5);
    chk("a5_valid", 16'(rx_valid), 16'h1);
    step(0, 0, 0, 0, 0, 0, "hold");
    send_word(8'h3C, 1'b0, "3c");
    chk("3c_par", 16'(ParOut), 16'h3C);
    chk("3c_ovr", 16'(overrun), 16'h1);
    step(0, 0, 0, 0, 1, 0, "oclr");
    chk("oclr_ovr", 16'(overrun), 16'h0);
    chk("oclr_par", 16'(ParOut), 16'h3C);
    send_word(8'hFF, 1'b1, "ff");
    chk("ff_valid", 16'(rx_valid), 16'h1);
    chk("ff_par", 16'(ParOut), 16'hFF);
    chk("ff_ovr", 16'(overrun), 16'h0);
    step(0, 0, 0, 1, 0, 0, "ack");
    chk("ack_valid", 16'(rx_valid), 16'h0);
    step(1, 1, 0, 0, 0, 0, "part");
    step(1, 1, 0, 0, 0, 0, "part");
    step(0, 1, 0, 0, 0, 0, "part");
    step(1, 1, 1, 0, 0, 0, "sync");
    chk("sync_busy", 16'(busy), 16'h1);
    for (int i = 0; i < 7; i++) step(i == 6, 1, 0, 0, 0, 0, "post");
    chk("sync_par", 16'(ParOut), 16'h81);
    chk("sync_ovr", 16'(overrun), 16'h0);
    step(0, 0, 0, 1, 0, 0, "ack2");
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, "pre");
    step(1, 1, 0, 0, 0, 1, "midclr");
    chk("midclr_busy", 16'(busy), 16'h0);
    chk("midclr_valid", 16'(rx_valid), 16'h0);
    send_word(8'h5A, 1'b0, "5a");
    chk("5a_par", 16'(ParOut), 16'h5A);
    chk("5a_valid", 16'(rx_valid), 16'h1);
    for (int i = 0; i < 600; i++)
      step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0, "rnd");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
